rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters.
- Requester 0 is ALU/execute writeback; requester 1 is load/memory writeback.
- Each requester has a valid/ready handshake into a one-entry holding buffer. Each cycle the block selects one buffered write and drives the register file write-enable/address/data inputs.
- Also exports a pending-write bitmap that the hazard logic uses to stall readers of registers with uncommitted writes.

---
 rtl/rf_pkg.sv | 8 +
 rtl/rf_write_arbiter_wb_slot.sv | 52 +++++
 rtl/rf_write_arbiter.sv | 104 ++++++++++
 tb/tb_rf_write_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-port arbiter.
package rf_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rf_write_arbiter_wb_slot.sv
// One-entry writeback holding buffer. Writes to x0 are accepted but never stored.
module wb_slot #(
   parameter int DATA_W = rf_pkg::DATA_W,
   parameter int ADDR_W = rf_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              loaded_o,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o
);
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   assign loaded_o = load_i && (addr_i != ADDR_W'(0));

   // A load wins over the clear so the slot can refill in the cycle it drains.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (loaded_o) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
         data_d  = data_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two writeback requesters onto the single register-file write port
// and publishes a bitmap of registers with uncommitted buffered writes.
module rf_write_arbiter #(
   parameter int DATA_W   = rf_pkg::DATA_W,
   parameter int ADDR_W   = rf_pkg::ADDR_W,
   parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                flush,
   input  logic                req0_valid,
   input  logic [ADDR_W-1:0]   req0_addr,
   input  logic [DATA_W-1:0]   req0_data,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [ADDR_W-1:0]   req1_addr,
   input  logic [DATA_W-1:0]   req1_data,
   output logic                req1_ready,
   output logic                rf_wr_en,
   output logic [ADDR_W-1:0]   rf_wr_addr,
   output logic [DATA_W-1:0]   rf_wr_data,
   output logic [NUM_REGS-1:0] pending
);
   import rf_pkg::*;

   logic              b0_v, b1_v, ld0, ld1;
   logic [ADDR_W-1:0] b0_a, b1_a;
   logic [DATA_W-1:0] b0_d, b1_d;
   logic              grant0, grant1;
   logic              rr_last_q, rr_last_d;
   logic              older_q, older_d;   // index of the buffer accepted first

   wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
      .clk(clk), .reset_n(reset_n),
      .load_i(req0_valid && req0_ready), .clear_i(grant0 || flush),
      .addr_i(req0_addr), .data_i(req0_data),
      .loaded_o(ld0), .valid_o(b0_v), .addr_o(b0_a), .data_o(b0_d)
   );

   wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
      .clk(clk), .reset_n(reset_n),
      .load_i(req1_valid && req1_ready), .clear_i(grant1 || flush),
      .addr_i(req1_addr), .data_i(req1_data),
      .loaded_o(ld1), .valid_o(b1_v), .addr_o(b1_a), .data_o(b1_d)
   );

   // Same-address conflicts follow acceptance order; otherwise round-robin.
   always_comb begin
      grant0 = 1'b0;
      if (b0_v && !b1_v)
         grant0 = 1'b1;
      else if (b0_v && b1_v)
         grant0 = (b0_a == b1_a) ? (older_q == 1'b0) : (rr_last_q == 1'b1);
      grant1 = b1_v && !grant0;
   end

   assign req0_ready = !flush && (!b0_v || grant0);
   assign req1_ready = !flush && (!b1_v || grant1);

   always_comb begin
      rr_last_d = rr_last_q;
      if (grant0)      rr_last_d = 1'b0;
      else if (grant1) rr_last_d = 1'b1;

      older_d = older_q;
      if (ld0 && ld1)
         older_d = 1'b0;
      else if (ld0 && b1_v && !grant1)
         older_d = 1'b1;
      else if (ld1 && b0_v && !grant0)
         older_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_last_q <= 1'b1;
         older_q   <= 1'b0;
      end else begin
         rr_last_q <= rr_last_d;
         older_q   <= older_d;
      end
   end

   always_comb begin
      rf_wr_en   = grant0 || grant1;
      rf_wr_addr = '0;
      rf_wr_data = '0;
      if (grant0) begin
         rf_wr_addr = b0_a;
         rf_wr_data = b0_d;
      end else if (grant1) begin
         rf_wr_addr = b1_a;
         rf_wr_data = b1_d;
      end
   end

   always_comb begin
      pending = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (ADDR_W'(r) != REG_ZERO)
            pending[r] = (b0_v && (b0_a == ADDR_W'(r))) || (b1_v && (b1_a == ADDR_W'(r)));
      end
   end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed vector table, reset/flush corners, then randomized traffic vs. an
// acceptance-order reference model.
module tb_rf_write_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [4:0]  req0_addr, req1_addr, rf_wr_addr;
   logic [31:0] req0_data, req1_data, rf_wr_data, pending;
   logic        rf_wr_en;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] rf_mem [32];

   rf_write_arbiter dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .pending(pending)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;

   typedef struct {
      logic        fl;
      logic        v0; logic [4:0] a0; logic [31:0] d0;
      logic        v1; logic [4:0] a1; logic [31:0] d1;
      logic        en; logic [4:0] wa; logic [31:0] wd;
      logic        r0, r1;
      logic [31:0] pend;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(logic fl, logic v0, logic [4:0] a0, logic [31:0] d0,
                               logic v1, logic [4:0] a1, logic [31:0] d1,
                               logic en, logic [4:0] wa, logic [31:0] wd,
                               logic r0, logic r1, logic [31:0] pend);
      vec_t v;
      v.fl = fl; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.en = en; v.wa = wa; v.wd = wd; v.r0 = r0; v.r1 = r1; v.pend = pend;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
      flush = fl;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
   endtask

   // reference model state: buffers tagged with acceptance sequence numbers
   bit          mv [2];
   logic [4:0]  ma [2];
   logic [31:0] md [2];
   int          ms [2];
   int          m_rr, seq;

   initial begin
      tbl[0]  = mk(0, 0,0,0,            0,0,0,            0,0,0,             1,1, 32'h0);
      tbl[1]  = mk(0, 1,5,32'hDEADBEEF, 0,0,0,            0,0,0,             1,1, 32'h0);
      tbl[2]  = mk(0, 0,0,0,            0,0,0,            1,5,32'hDEADBEEF,  1,1, 32'h20);
      tbl[3]  = mk(0, 0,0,0,            0,0,0,            0,0,0,             1,1, 32'h0);
      tbl[4]  = mk(0, 1,9,32'h1,        1,9,32'h2,        0,0,0,             1,1, 32'h0);
      tbl[5]  = mk(0, 0,0,0,            0,0,0,            1,9,32'h1,         1,0, 32'h200);
      tbl[6]  = mk(0, 0,0,0,            0,0,0,            1,9,32'h2,         1,1, 32'h200);
      tbl[7]  = mk(0, 0,0,0,            0,0,0,            0,0,0,             1,1, 32'h0);
      tbl[8]  = mk(0, 0,0,0,            1,0,32'hFFFFFFFF, 0,0,0,             1,1, 32'h0);
      tbl[9]  = mk(0, 0,0,0,            0,0,0,            0,0,0,             1,1, 32'h0);
      tbl[10] = mk(0, 1,3,32'h10,       1,7,32'h20,       0,0,0,             1,1, 32'h0);
      tbl[11] = mk(0, 1,3,32'h11,       1,7,32'h21,       1,3,32'h10,        1,0, 32'h88);
      tbl[12] = mk(0, 1,3,32'h12,       1,7,32'h21,       1,7,32'h20,        0,1, 32'h88);
      tbl[13] = mk(0, 1,3,32'h12,       1,7,32'h22,       1,3,32'h11,        1,0, 32'h88);
      tbl[14] = mk(0, 0,0,0,            0,0,0,            1,7,32'h21,        0,1, 32'h88);
      tbl[15] = mk(0, 0,0,0,            0,0,0,            1,3,32'h12,        1,1, 32'h8);
      tbl[16] = mk(0, 1,4,32'h40,       1,6,32'h60,       0,0,0,             1,1, 32'h0);
      tbl[17] = mk(1, 0,0,0,            0,0,0,            1,6,32'h60,        0,0, 32'h50);
      tbl[18] = mk(0, 0,0,0,            0,0,0,            0,0,0,             1,1, 32'h0);

      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      reset_n = 1'b0;
      drive(0, 0,0,0, 0,0,0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].fl, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
         @(negedge clk);
         chk($sformatf("row%0d wr_en", i),   rf_wr_en,   tbl[i].en);
         chk($sformatf("row%0d wr_addr", i), rf_wr_addr, tbl[i].wa);
         chk($sformatf("row%0d wr_data", i), rf_wr_data, tbl[i].wd);
         chk($sformatf("row%0d ready0", i),  req0_ready, tbl[i].r0);
         chk($sformatf("row%0d ready1", i),  req1_ready, tbl[i].r1);
         chk($sformatf("row%0d pending", i), pending,    tbl[i].pend);
         if (i == 7) chk("x9 final value", rf_mem[9], 32'h2);
         @(posedge clk); #1;
      end

      // fill both buffers, then pull reset mid-cycle
      drive(0, 1,4,32'hA, 1,6,32'hB);
      @(posedge clk); #1;
      drive(0, 0,0,0, 0,0,0);
      @(negedge clk);
      chk("pre-reset pending", pending, 32'h50);
      #2 reset_n = 1'b0;
      #1;
      chk("async reset wr_en", rf_wr_en, 1'b0);
      chk("async reset pending", pending, 32'h0);
      @(posedge clk); #1 reset_n = 1'b1;

      mv[0] = 0; mv[1] = 0; m_rr = 1; seq = 0;
      for (int c = 0; c < 3000; c++) begin
         bit          fl, vin [2];
         logic [4:0]  ain [2];
         logic [31:0] din [2];
         int          g;
         bit          er [2];
         logic [4:0]  ewa;
         logic [31:0] ewd, epend;
         fl = ($urandom_range(0, 19) == 0);
         for (int n = 0; n < 2; n++) begin
            vin[n] = ($urandom_range(0, 9) < 6);
            ain[n] = 5'($urandom_range(0, 7));
            din[n] = $urandom;
         end
         drive(fl, vin[0], ain[0], din[0], vin[1], ain[1], din[1]);
         @(negedge clk);

         g = -1;
         if (mv[0] && mv[1])
            g = (ma[0] == ma[1]) ? ((ms[0] < ms[1]) ? 0 : 1) : 1 - m_rr;
         else if (mv[0]) g = 0;
         else if (mv[1]) g = 1;
         ewa = (g >= 0) ? ma[g] : 5'd0;
         ewd = (g >= 0) ? md[g] : 32'd0;
         epend = '0;
         for (int n = 0; n < 2; n++) begin
            if (mv[n]) epend[ma[n]] = 1'b1;
            er[n] = !fl && (!mv[n] || g == n);
         end
         chk($sformatf("rnd%0d wr_en", c),   rf_wr_en,   (g >= 0));
         chk($sformatf("rnd%0d wr_addr", c), rf_wr_addr, ewa);
         chk($sformatf("rnd%0d wr_data", c), rf_wr_data, ewd);
         chk($sformatf("rnd%0d ready0", c),  req0_ready, er[0]);
         chk($sformatf("rnd%0d ready1", c),  req1_ready, er[1]);
         chk($sformatf("rnd%0d pending", c), pending,    epend);

         if (g >= 0) begin mv[g] = 0; m_rr = g; end
         if (fl) begin
            mv[0] = 0; mv[1] = 0;
         end else begin
            for (int n = 0; n < 2; n++)
               if (vin[n] && er[n] && ain[n] != 5'd0) begin
                  mv[n] = 1; ma[n] = ain[n]; md[n] = din[n]; ms[n] = seq + n;
               end
         end
         seq += 2;
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
